// File: rtl/bet_latch_driver.sv
// Sequencer feeding the BET ternary D-latch from a trit command stream.
// Keeps data legal (never 00) and never moves data and enable together.
module bet_latch_driver #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_trit,
    output logic [2:0] latch_in,
    input  logic [1:0] latch_q,
    output logic       busy,
    output logic       done,
    output logic       mismatch,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        SETUP,
        PULSE,
        HOLD,
        CHECK
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [1:0]       r_tgt;
    logic [1:0]       w_tgt_nx;
    logic [2:0]       r_latch_in;
    logic [2:0]       w_latch_in_nx;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_done_nx;
    logic             r_mismatch;
    logic             w_mismatch_nx;
    logic             r_err;
    logic             w_err_nx;
    logic [1:0]       w_code;

    always_comb begin
        unique case (cmd_trit)
            2'd0:    w_code = 2'b01;
            2'd1:    w_code = 2'b11;
            default: w_code = 2'b10;
        endcase
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt + CNT_W'(1);
        w_tgt_nx      = r_tgt;
        w_latch_in_nx = r_latch_in;
        w_done_nx     = 1'b0;
        w_mismatch_nx = 1'b0;
        w_err_nx      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (cmd_valid) begin
                    if (cmd_trit == 2'd3) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_tgt_nx = w_code;
                        // 01<->10 would pass through 00 or flip both bits
                        if ((r_latch_in[1:0] ^ w_code) == 2'b11) begin
                            w_state_nx    = STEP;
                            w_latch_in_nx = 3'b011;
                        end else begin
                            w_state_nx    = SETUP;
                            w_latch_in_nx = {1'b0, w_code};
                        end
                    end
                end
            end
            STEP: begin
                w_state_nx    = SETUP;
                w_cnt_nx      = '0;
                w_latch_in_nx = {1'b0, r_tgt};
            end
            SETUP: begin
                if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                    w_state_nx       = PULSE;
                    w_cnt_nx         = '0;
                    w_latch_in_nx[2] = 1'b1;
                end
            end
            PULSE: begin
                if (r_cnt == CNT_W'(PULSE_CYC - 1)) begin
                    w_state_nx       = HOLD;
                    w_cnt_nx         = '0;
                    w_latch_in_nx[2] = 1'b0;
                end
            end
            HOLD: begin
                if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                    w_state_nx    = CHECK;
                    w_cnt_nx      = '0;
                    w_done_nx     = 1'b1;
                    w_mismatch_nx = (latch_q != r_tgt);
                end
            end
            CHECK: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_tgt      <= 2'b11;
            r_latch_in <= 3'b011;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_tgt      <= w_tgt_nx;
            r_latch_in <= w_latch_in_nx;
            r_ready    <= (w_state_nx == IDLE);
            r_busy     <= (w_state_nx != IDLE);
            r_done     <= w_done_nx;
            r_mismatch <= w_mismatch_nx;
            r_err      <= w_err_nx;
        end
    end

    assign latch_in  = r_latch_in;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign mismatch  = r_mismatch;
    assign err       = r_err;

endmodule

// File: tb/tb_bet_latch_driver.sv
// Bench for bet_latch_driver: directed and random trit writes against
// a timeline model built from the BET code and phase lengths.
module tb_bet_latch_driver;

    localparam int S = 2;
    localparam int P = 2;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_trit;
    logic [2:0] latch_in;
    logic [1:0] latch_q;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic       err;

    logic       force00 = 1'b0;
    logic [1:0] q_store = 2'b11;
    logic [1:0] cur;
    int         errors  = 0;
    int         checks  = 0;

    bet_latch_driver #(
        .SETUP_CYC(S),
        .PULSE_CYC(P),
        .HOLD_CYC (H),
        .CNT_W    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_trit (cmd_trit),
        .latch_in (latch_in),
        .latch_q  (latch_q),
        .busy     (busy),
        .done     (done),
        .mismatch (mismatch),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Latch model: captures data while enable is high
    always @(posedge clk) begin
        if (latch_in[2]) q_store <= latch_in[1:0];
    end
    assign latch_q = force00 ? 2'b00 : q_store;

    function automatic logic [1:0] bet(input int t);
        logic [1:0] c;
        if (t == 0) c = 2'b01;
        else if (t == 1) c = 2'b11;
        else c = 2'b10;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int t, input bit f00);
        logic [1:0] code;
        bit         step;
        int         tot;
        int         en_lo;
        int         en_hi;
        logic [1:0] d;
        logic       en;
        code  = bet(t);
        step  = ((cur ^ code) == 2'b11);
        tot   = int'(step) + S + P + H + 1;
        en_lo = int'(step) + S + 1;
        en_hi = int'(step) + S + P;
        @(negedge clk);
        check("wr_ready_pre", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_trit  = 2'(t);
        force00   = f00;
        @(posedge clk);
        for (int c = 1; c <= tot; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            d  = (step && c == 1) ? 2'b11 : code;
            en = (c >= en_lo && c <= en_hi);
            check("wr_latch_in", 32'(latch_in), 32'({en, d}));
            check("wr_done", 32'(done), 32'(c == tot));
            check("wr_mismatch", 32'(mismatch), 32'(c == tot && f00));
            check("wr_busy", 32'(busy), 32'd1);
            check("wr_ready", 32'(cmd_ready), 32'd0);
            check("wr_err", 32'(err), 32'd0);
        end
        @(negedge clk);
        check("wr_ready_post", 32'(cmd_ready), 32'd1);
        check("wr_busy_post", 32'(busy), 32'd0);
        check("wr_done_post", 32'(done), 32'd0);
        if (!f00) check("wr_latch_q", 32'(latch_q), 32'(code));
        force00 = 1'b0;
        cur     = code;
    endtask

    task automatic do_invalid();
        logic [2:0] li;
        @(negedge clk);
        li        = latch_in;
        cmd_valid = 1'b1;
        cmd_trit  = 2'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("inv_err", 32'(err), 32'd1);
        check("inv_latch_in", 32'(latch_in), 32'(li));
        check("inv_ready", 32'(cmd_ready), 32'd1);
        check("inv_done", 32'(done), 32'd0);
        check("inv_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("inv_err_drop", 32'(err), 32'd0);
        check("inv_latch_in2", 32'(latch_in), 32'(li));
    endtask

    initial begin
        int         cmds [3];
        int         hs;
        int         dn;
        int         st_seen;
        int         st_exp;
        int         n;
        int         t;
        logic [1:0] code;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_trit  = 2'd0;
        cur       = 2'b11;
        repeat (2) @(negedge clk);
        check("rst_latch_in", 32'(latch_in), 32'h3);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        do_write(2, 1'b0);
        do_write(0, 1'b0);
        do_invalid();
        do_write(1, 1'b1);

        // Reset during the enable pulse
        code = bet(2);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_trit  = 2'd2;
        @(posedge clk);
        for (int c = 1; c <= S + 2; c++) @(negedge clk);
        cmd_valid = 1'b0;
        check("rp_enable", 32'(latch_in), 32'({1'b1, code}));
        rst_n = 1'b0;
        #1;
        check("rp_latch_in", 32'(latch_in), 32'h3);
        check("rp_busy", 32'(busy), 32'd0);
        check("rp_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cur   = 2'b11;
        do_write(0, 1'b0);

        // Back-to-back with valid held high
        do_write(1, 1'b0);
        cmds    = '{0, 2, 1};
        hs      = 0;
        dn      = 0;
        st_seen = 0;
        st_exp  = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_trit  = 2'(cmds[0]);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!cmd_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("b2b_ready_wait", 32'(cmd_ready), 32'd1);
            code = bet(cmds[k]);
            if ((cur ^ code) == 2'b11) st_exp++;
            @(posedge clk);
            hs++;
            @(negedge clk);
            if (latch_in[1:0] == 2'b11 && code != 2'b11) st_seen++;
            if (k < 2) cmd_trit = 2'(cmds[k+1]);
            else cmd_valid = 1'b0;
            n = 0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("b2b_done_wait", 32'(done), 32'd1);
            if (done) dn++;
            @(negedge clk);
            cur = code;
        end
        check("b2b_handshakes", 32'(hs), 32'd3);
        check("b2b_dones", 32'(dn), 32'd3);
        check("b2b_steps", 32'(st_seen), 32'(st_exp));
        check("b2b_steps_one", 32'(st_seen), 32'd1);

        for (int i = 0; i < 24; i++) begin
            t = int'($urandom_range(0, 3));
            if (t == 3) do_invalid();
            else do_write(t, ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
